me_stage: RTL
=============

ME_STAGE -- requirements
Module: me_stage

Interface
REQ-001 Parameters: none; widths fixed at 32-bit data/address.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 EX_valid  in  1  EX stage holds valid instruction/results.
REQ-005 ready  out  1  stage accepts EX payload this cycle (EX's ME_ready).
REQ-006 valid  out  1  output payload valid toward WB.
REQ-007 WB_ready  in  1  WB consumes payload this cycle.
REQ-008 opcode 7, funct3 3, rd_group 2, rd_index 5  in  instruction fields from EX.
REQ-009 npc 32, res_R 32, res_F 32, st_data 32  in  EX results; res_R is effective address for load/store.
REQ-010 mem_req  out  1; mem_we  out  1; mem_addr  out  32 word-aligned; mem_wdata  out  32; mem_wstrb  out  4.
REQ-011 mem_gnt  in  1 request accepted; mem_rvalid  in  1 read data returned; mem_rdata  in  32.
REQ-012 o_rd_group 2, o_rd_index 5, o_npc 32, o_res_R 32, o_res_F 32, misalign 1  out  registered payload to WB.

Function
REQ-013 Accept = ready & EX_valid; ready = (state==IDLE) & (!valid | WB_ready).
REQ-014 States: IDLE, REQ, WAIT; all outputs registered.
REQ-015 Non-memory opcode (not 0000011/0100011): on accept, payload copied, valid=1 next cycle (latency 1), state stays IDLE.
REQ-016 Load (0000011) or store (0100011), aligned: on accept latch fields, IDLE->REQ, mem_req=1 next cycle.
REQ-017 REQ: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb held stable until mem_gnt=1; on gnt mem_req drops same edge.
REQ-018 Store on gnt: REQ->IDLE, valid=1 next cycle, o_res_R = res_R.
REQ-019 Load on gnt: REQ->WAIT; WAIT until mem_rvalid=1, then IDLE, valid=1 next cycle with o_res_R = extracted load data.
REQ-020 mem_rvalid same cycle as gnt: ignored; response accepted only in WAIT.
REQ-021 mem_addr = {res_R[31:2],2'b00}; byte offset = res_R[1:0].
REQ-022 Store: SB(000) wstrb=0001<<off, wdata=byte replicated x4; SH(001) wstrb=0011<<off, halfword replicated x2; SW(010) wstrb=1111, wdata=st_data.
REQ-023 Load: LB 000/LBU 100 select byte off, LH 001/LHU 101 select half off[1]; signed variants sign-extend, unsigned zero-extend; LW 010 whole word.
REQ-024 Misaligned (half with off[0]=1, word with off!=0): no bus request, misalign=1, valid next cycle, o_res_R = res_R, state stays IDLE.
REQ-025 valid & !WB_ready: entire output payload held unchanged; valid clears on WB_ready unless new payload completes same edge.
REQ-026 Back-to-back non-memory ops sustain one per cycle when WB_ready=1.
REQ-027 mem_we=1 only for stores; mem_wstrb=0 for loads.

Reset
REQ-028 rst low asynchronously forces state=IDLE, valid=0, mem_req=0, mem_we=0, mem_wstrb=0, misalign=0, all payload/address/data outputs 0.
REQ-029 Reset mid-REQ or mid-WAIT abandons transaction; later mem_rvalid ignored while IDLE.
REQ-030 After rst rises, ready=1 in first cycle.

Verification
REQ-031 Non-memory, WB_ready=1: res_R=0x00000123 accepted -> valid next cycle, o_res_R=0x00000123, no mem_req.
REQ-032 LB res_R=0x1003, gnt after 2 cycles, rvalid 3 cycles later rdata=0x80FFFFFF -> mem_addr=0x1000, o_res_R=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH res_R=0x2002, st_data=0x0000BEEF -> mem_wstrb=1100, mem_wdata=0xBEEFBEEF, mem_we=1 until gnt, then valid.
REQ-034 LW res_R=0x3001 -> misalign=1, mem_req never asserted, valid next cycle.
REQ-035 WB_ready=0 for 4 cycles with valid=1 -> payload stable, ready=0, EX payload not consumed; rst low during WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/me_stage.sv
// Memory stage: forwards ALU results to WB, or runs one load/store bus transaction
// (IDLE -> REQ -> [WAIT]) and returns aligned, extended load data.
module me_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_valid,
  output logic        ready,
  output logic        valid,
  input  logic        WB_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  rd_group,
  input  logic [4:0]  rd_index,
  input  logic [31:0] npc,
  input  logic [31:0] res_R,
  input  logic [31:0] res_F,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_rd_group,
  output logic [4:0]  o_rd_index,
  output logic [31:0] o_npc,
  output logic [31:0] o_res_R,
  output logic [31:0] o_res_F,
  output logic        misalign
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_is_load;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misal;
  logic        w_accept;
  logic        w_go_mem;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      2'b10:   store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'h000000, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'h0000, h};
      default: load_extract = d;
    endcase
  endfunction

  assign ready    = (r_state == S_IDLE) & (~valid | WB_ready);
  assign w_accept = ready & EX_valid;

  // Decode the incoming instruction: memory class and alignment
  always_comb begin
    w_is_load  = (opcode == OP_LOAD);
    w_is_store = (opcode == OP_STORE);
    w_misal    = 1'b0;
    if (w_is_load | w_is_store) begin
      case (funct3[1:0])
        2'b01:   w_misal = res_R[0];
        2'b10:   w_misal = (res_R[1:0] != 2'b00);
        default: w_misal = 1'b0;
      endcase
    end else begin
      w_misal = 1'b0;
    end
    w_go_mem = w_accept & (w_is_load | w_is_store) & ~w_misal;
  end

  // Next-state logic for the bus transaction sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go_mem) w_next_state = S_REQ;
        else          w_next_state = S_IDLE;
      end
      S_REQ: begin
        if (mem_gnt) w_next_state = r_is_load ? S_WAIT : S_IDLE;
        else         w_next_state = S_REQ;
      end
      S_WAIT: begin
        if (mem_rvalid) w_next_state = S_IDLE;
        else            w_next_state = S_WAIT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Output payload and bus request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= 1'b0;
      misalign   <= 1'b0;
      o_rd_group <= 2'b00;
      o_rd_index <= 5'd0;
      o_npc      <= 32'h0;
      o_res_R    <= 32'h0;
      o_res_F    <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'b0000;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_is_load  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Old payload is either consumed this edge or was not valid
            o_rd_group <= rd_group;
            o_rd_index <= rd_index;
            o_npc      <= npc;
            o_res_R    <= res_R;
            o_res_F    <= res_F;
            misalign   <= w_misal;
            r_funct3   <= funct3;
            r_off      <= res_R[1:0];
            r_is_load  <= w_is_load;
            if (w_go_mem) begin
              valid     <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= w_is_store;
              mem_addr  <= {res_R[31:2], 2'b00};
              mem_wdata <= w_is_store ? store_data(funct3, st_data) : 32'h0;
              mem_wstrb <= w_is_store ? store_strb(funct3, res_R[1:0]) : 4'b0000;
            end else begin
              valid <= 1'b1;
            end
          end else if (WB_ready) begin
            valid <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (!r_is_load) valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            valid   <= 1'b1;
            o_res_R <= load_extract(r_funct3, r_off, mem_rdata);
          end
        end
        default: valid <= 1'b0;
      endcase
    end
  end

endmodule
